// File: rtl/mult_job_sequencer_if.sv
// Request/response bundle between two job requesters and the shared multiplier sequencer.
// The sequencer takes the slave side; the requesters and the result consumer take the master side.
interface mult_job_sequencer_if #(
   parameter int WIDTH = 8
);
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [2*WIDTH-1:0] req_a;
   logic [2*WIDTH-1:0] req_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic               rsp_id;
   logic [2*WIDTH-1:0] rsp_prod;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_prod
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_prod
   );
endinterface

// File: rtl/mult_job_sequencer.sv
// Control path for the shared add-shift signed multiplier: round-robin job intake,
// fixed-latency add/sub+shift stepping of the external datapath, and product return.
module mult_job_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   mult_job_sequencer_if.slave bus,
   output logic             dp_clr,
   output logic             dp_ld,
   output logic [WIDTH-1:0] dp_sval,
   output logic [WIDTH-1:0] dp_bval,
   output logic             dp_add,
   output logic             dp_sub,
   output logic             dp_shift,
   input  logic             dp_m,
   input  logic [WIDTH-1:0] dp_a,
   input  logic [WIDTH-1:0] dp_b
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      OP,
      SHIFT,
      CAPT,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 rrPri_q, rrPri_d;
   logic                 id_q, id_d;
   logic [WIDTH-1:0]     sval_q, sval_d;
   logic [WIDTH-1:0]     bval_q, bval_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic [1:0]           grant;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rrPri_q <= 1'b0;
         id_q    <= 1'b0;
         sval_q  <= '0;
         bval_q  <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rrPri_q <= rrPri_d;
         id_q    <= id_d;
         sval_q  <= sval_d;
         bval_q  <= bval_d;
         prod_q  <= prod_d;
      end
   end

   // Strobes come only from the registered state so a requester can never glitch the datapath.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rrPri_d       = rrPri_q;
      id_d          = id_q;
      sval_d        = sval_q;
      bval_d        = bval_q;
      prod_d        = prod_q;
      grant         = 2'b00;
      dp_clr        = 1'b0;
      dp_ld         = 1'b0;
      dp_add        = 1'b0;
      dp_sub        = 1'b0;
      dp_shift      = 1'b0;
      bus.rsp_valid = 1'b0;

      case (state_q)
         IDLE: begin
            grant[0] = bus.req_valid[0] && (rrPri_q == 1'b0 || !bus.req_valid[1]);
            grant[1] = bus.req_valid[1] && (rrPri_q == 1'b1 || !bus.req_valid[0]);
            if (grant != 2'b00) begin
               id_d    = grant[1];
               rrPri_d = ~grant[1];
               sval_d  = grant[1] ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
               bval_d  = grant[1] ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
               state_d = LOAD;
            end
         end
         LOAD: begin
            dp_clr  = 1'b1;
            dp_ld   = 1'b1;
            cnt_d   = '0;
            state_d = OP;
         end
         OP: begin
            // The multiplier's top bit carries negative weight, so it subtracts.
            if (dp_m) begin
               if (cnt_q == CNT_MAX) dp_sub = 1'b1;
               else                  dp_add = 1'b1;
            end
            state_d = SHIFT;
         end
         SHIFT: begin
            dp_shift = 1'b1;
            if (cnt_q == CNT_MAX) begin
               state_d = CAPT;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = OP;
            end
         end
         CAPT: begin
            prod_d  = {dp_a, dp_b};
            state_d = DONE;
         end
         DONE: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready = grant;
   assign bus.rsp_id    = id_q;
   assign bus.rsp_prod  = prod_q;
   assign dp_sval       = sval_q;
   assign dp_bval       = bval_q;
endmodule
